piso_serializer: RTL and testbench

- Parallel-in/serial-out transmitter that generates the single-bit serial data stream a D-flop capture chain samples.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk, with a serial valid qualifier and framing flags.
- Sits between a parallel data source and any serial sink built from the team's flop primitives.

---
 rtl/piso_serializer_if.sv | 24 ++
 rtl/piso_serializer.sv | 108 ++++++++++
 tb/tb_piso_serializer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Parallel-in / serial-out handshake bundle: word input side plus serial output side.
// The slave modport is the serializer; the master modport is whoever feeds words and watches the line.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_first;
  logic             sout_last;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, sout_first, sout_last, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, sout_first, sout_last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// WIDTH-bit parallel-to-serial transmitter with framing flags; back-to-back frames without gaps.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of every frame.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                reset,
  piso_serializer_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    bit_cnt;
`ifdef PISO_PARITY_EN
  logic             parity_bit;
`endif

  logic in_idle;
  logic in_shift;
  logic last_data;
  logic data_bit;
  logic ready;
  logic accept;

  assign in_idle   = (state == IDLE);
  assign in_shift  = (state == SHIFT);
  assign last_data = in_shift && (bit_cnt == LAST_CNT);
  assign data_bit  = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];
  assign shifted   = (MSB_FIRST != 0) ? {shift_reg[WIDTH-2:0], 1'b0}
                                      : {1'b0, shift_reg[WIDTH-1:1]};

`ifdef PISO_PARITY_EN
  logic in_parity;
  assign in_parity = (state == PARITY);
  // The frame ends on the parity cycle, so that is where the next word may be taken.
  assign ready     = in_idle || in_parity;
`else
  assign ready     = in_idle || last_data;
`endif

  assign accept = bus.din_valid && ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
`ifdef PISO_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (accept) begin
      state      <= SHIFT;
      shift_reg  <= bus.din;
      bit_cnt    <= '0;
`ifdef PISO_PARITY_EN
      parity_bit <= ^bus.din;
`endif
    end else begin
      case (state)
        SHIFT: begin
          shift_reg <= shifted;
          if (last_data) begin
            bit_cnt <= '0;
`ifdef PISO_PARITY_EN
            state   <= PARITY;
`else
            state   <= IDLE;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef PISO_PARITY_EN
        PARITY:  state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; reset clears them without waiting for a clock.
  assign bus.din_ready  = ready;
  assign bus.sout_first = in_shift && (bit_cnt == '0);
`ifdef PISO_PARITY_EN
  assign bus.sout       = in_shift ? data_bit : (in_parity && parity_bit);
  assign bus.sout_valid = in_shift || in_parity;
  assign bus.sout_last  = in_parity;
  assign bus.busy       = in_shift || in_parity;
`else
  assign bus.sout       = in_shift && data_bit;
  assign bus.sout_valid = in_shift;
  assign bus.sout_last  = last_data;
  assign bus.busy       = in_shift;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: an MSB-first and an LSB-first serializer driven with the same words,
// checked against hand-computed bit streams, plus back-to-back, hold-off and reset-abort sequences.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  // ms/ls: bits in transmission order, bit [7] leaves first; par: even parity of din.
  typedef struct {
    logic [7:0] din;
    logic [7:0] ms;
    logic [7:0] ls;
    logic       par;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  piso_serializer_if #(.WIDTH(8)) m_if ();
  piso_serializer_if #(.WIDTH(8)) l_if ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (.clk(clk), .reset(reset), .bus(m_if.slave));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (.clk(clk), .reset(reset), .bus(l_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] d, input logic v);
    m_if.din = d; m_if.din_valid = v;
    l_if.din = d; l_if.din_valid = v;
  endtask

  function automatic logic exp_bit(input vec_t v, input int k, input bit msb);
    logic [7:0] s;
    s = msb ? v.ms : v.ls;
    return (k < 8) ? s[7-k] : v.par;
  endfunction

  task automatic check_out(input string tag, input logic em, input logic el, input logic ev,
                           input logic ef, input logic elast, input logic er);
    check({tag, ".m.sout"},  32'(m_if.sout),       32'(em));
    check({tag, ".l.sout"},  32'(l_if.sout),       32'(el));
    check({tag, ".m.valid"}, 32'(m_if.sout_valid), 32'(ev));
    check({tag, ".l.valid"}, 32'(l_if.sout_valid), 32'(ev));
    check({tag, ".m.first"}, 32'(m_if.sout_first), 32'(ef));
    check({tag, ".l.first"}, 32'(l_if.sout_first), 32'(ef));
    check({tag, ".m.last"},  32'(m_if.sout_last),  32'(elast));
    check({tag, ".l.last"},  32'(l_if.sout_last),  32'(elast));
    check({tag, ".m.busy"},  32'(m_if.busy),       32'(ev));
    check({tag, ".l.busy"},  32'(l_if.busy),       32'(ev));
    check({tag, ".m.ready"}, 32'(m_if.din_ready),  32'(er));
    check({tag, ".l.ready"}, 32'(l_if.din_ready),  32'(er));
  endtask

  task automatic check_idle(input string tag);
    check_out(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Called just after a negedge with the block idle; leaves just after a negedge, idle again.
  task automatic run_vec(input string tag, input vec_t v);
    set_in(v.din, 1'b1);
    @(negedge clk);
    set_in(8'h00, 1'b0);
    for (int k = 0; k < FL; k++) begin
      check_out($sformatf("%s[%0d]", tag, k), exp_bit(v, k, 1'b1), exp_bit(v, k, 1'b0),
                1'b1, k == 0, k == FL - 1, k == FL - 1);
      @(negedge clk);
    end
    check_idle({tag, ".after"});
  endtask

  // Two frames; v2 is presented from frame-1 cycle start2 on and must follow with no gap.
  task automatic run_pair(input string tag, input vec_t v1, input vec_t v2,
                          input bit hold1, input int start2);
    set_in(v1.din, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 2 * FL; k++) begin
      int   kk;
      vec_t f;
      kk = k % FL;
      f  = (k < FL) ? v1 : v2;
      check_out($sformatf("%s[%0d]", tag, k), exp_bit(f, kk, 1'b1), exp_bit(f, kk, 1'b0),
                1'b1, kk == 0, kk == FL - 1, kk == FL - 1);
      if (k == 0 && !hold1) set_in(8'h00, 1'b0);
      if (k == start2)      set_in(v2.din, 1'b1);
      if (k == FL)          set_in(8'h00, 1'b0);
      @(negedge clk);
    end
    check_idle({tag, ".after"});
  endtask

  vec_t vecs [7];
  vec_t v_a5, v_3c, v_01, v_ff;

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{din: 8'hA5, ms: 8'hA5, ls: 8'hA5, par: 1'b0};
    vecs[1] = '{din: 8'h01, ms: 8'h01, ls: 8'h80, par: 1'b1};
    vecs[2] = '{din: 8'hFF, ms: 8'hFF, ls: 8'hFF, par: 1'b0};
    vecs[3] = '{din: 8'h07, ms: 8'h07, ls: 8'hE0, par: 1'b1};
    vecs[4] = '{din: 8'h03, ms: 8'h03, ls: 8'hC0, par: 1'b0};
    vecs[5] = '{din: 8'h3C, ms: 8'h3C, ls: 8'h3C, par: 1'b0};
    vecs[6] = '{din: 8'h12, ms: 8'h12, ls: 8'h48, par: 1'b0};
    v_a5 = vecs[0];
    v_01 = vecs[1];
    v_ff = vecs[2];
    v_3c = vecs[5];

    reset = 1'b0;
    set_in(8'h00, 1'b0);
    #1;
    check_idle("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle[%0d]", i));
    end

    for (int i = 0; i < 7; i++)
      run_vec($sformatf("vec%0d", i), vecs[i]);

    run_pair("b2b", v_a5, v_3c, 1'b1, FL - 1);
    run_pair("hold", v_01, v_ff, 1'b0, 3);

    // Abort an A5 frame after three bits while a new word is offered during reset.
    set_in(v_a5.din, 1'b1);
    @(negedge clk);
    set_in(8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check_out($sformatf("abort[%0d]", k), exp_bit(v_a5, k, 1'b1), exp_bit(v_a5, k, 1'b0),
                1'b1, k == 0, 1'b0, 1'b0);
      @(negedge clk);
    end
    check({"abort.pre.busy"}, 32'(m_if.busy), 32'd1);
    reset = 1'b0;
    set_in(8'hFF, 1'b1);
    #1;
    check_idle("abort.async");
    @(negedge clk);
    check_idle("abort.held");
    reset = 1'b1;
    set_in(8'h00, 1'b0);
    #1;
    check_idle("abort.release");
    @(negedge clk);
    check_idle("abort.noaccept");
    run_vec("post_reset", v_ff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
